// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Single-port memory responder for a single-cycle MIPS datapath.
//            Arbitrates the instruction and data ports onto one fixed-latency
//            RAM (data has priority), stalls each requester with a wait
//            signal until its access completes, and parks after a halt
//            once the RAM has drained.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int LAT = 2            // RAM access latency in cycles, 1..15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  output logic        err,
  output logic        halted
);

  localparam logic [3:0] c_lat = 4'(LAT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DACC   = 3'd1,
    ST_IACC   = 3'd2,
    ST_TURN   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_dwrite;        // data access was entered as a write
  logic        w_dwrite_next;
  logic        r_err;

  logic        w_d_req;
  logic        w_d_done;
  logic        w_i_done;

  // A port completes only in the final latency cycle while it still requests.
  assign w_d_req  = dREN | dWEN;
  assign w_d_done = (r_state == ST_DACC) && (r_cnt == c_lat) && w_d_req;
  assign w_i_done = (r_state == ST_IACC) && (r_cnt == c_lat) && iREN;

  // State, latency counter, access type and sticky error registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_dwrite <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_next;
      r_dwrite <= w_dwrite_next;
      if ((r_state == ST_DACC) && dREN && dWEN) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next-state logic: data before instruction, a turnaround after every
  // access so the requester's stale request is never re-sampled.
  always_comb begin
    w_next_state  = r_state;
    w_cnt_next    = r_cnt;
    w_dwrite_next = r_dwrite;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = 4'd0;
        if (halt) begin
          w_next_state = ST_HALTED;
        end else if (w_d_req) begin
          w_next_state  = ST_DACC;
          w_cnt_next    = 4'd1;
          w_dwrite_next = dWEN;
        end else if (iREN) begin
          w_next_state = ST_IACC;
          w_cnt_next   = 4'd1;
        end
      end
      ST_DACC: begin
        if (!w_d_req || (r_cnt == c_lat)) begin
          w_next_state = ST_TURN;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      ST_IACC: begin
        if (!iREN || (r_cnt == c_lat)) begin
          w_next_state = ST_TURN;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      ST_TURN: begin
        w_cnt_next   = 4'd0;
        w_next_state = halt ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        w_cnt_next = 4'd0;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // RAM side is driven from the live request inputs, gated by state.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    case (r_state)
      ST_DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
      end
      ST_IACC: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  // CPU side: waits drop only on completion, read data shown only then.
  always_comb begin
    halted = (r_state == ST_HALTED);
    err    = r_err;
    iwait  = halted | (iREN & ~w_i_done);
    dwait  = halted | (w_d_req & ~w_d_done);
    iload  = w_i_done ? ramload : 32'd0;
    dload  = (w_d_done && !r_dwrite) ? ramload : 32'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus a
//            randomized request phase, checked every cycle against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        halt;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        err;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  // Reference model: which port owns the RAM, the cycle its access began,
  // whether a turnaround cycle is in progress, and the parked/error flags.
  int m_cyc;
  int m_kind;     // 0 = no access, 1 = data, 2 = instruction
  int m_first;
  bit m_turn;
  bit m_parked;
  bit m_err;
  bit m_wr;

  mem_arbiter #(.LAT(LAT)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload),
    .err(err), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_kind = 0; m_first = 0;
    m_turn = 0; m_parked = 0; m_err = 0; m_wr = 0;
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic model_edge();
    bit req_live;
    if (!nRST) begin
      model_reset();
      return;
    end
    req_live = (m_kind == 1) ? (dREN | dWEN) : iREN;
    if (m_parked) begin
      // parked until reset
    end else if (m_turn) begin
      m_turn = 0;
      if (halt) m_parked = 1;
    end else if (m_kind != 0) begin
      if (m_kind == 1 && dREN && dWEN) m_err = 1;
      if (!req_live || (m_cyc - m_first + 1 == LAT)) begin
        m_kind = 0;
        m_turn = 1;
      end
    end else if (halt) begin
      m_parked = 1;
    end else if (dREN | dWEN) begin
      m_kind = 1; m_first = m_cyc + 1; m_wr = dWEN;
    end else if (iREN) begin
      m_kind = 2; m_first = m_cyc + 1;
    end
    m_cyc++;
  endtask

  // Compare every output with the model for the current cycle.
  task automatic check_all(input string tag);
    bit          last, d_done, i_done;
    logic [31:0] e_addr, e_store;
    bit          e_ren, e_wen;
    last    = (m_kind != 0) && (m_cyc - m_first + 1 == LAT);
    d_done  = (m_kind == 1) && last && (dREN | dWEN);
    i_done  = (m_kind == 2) && last && iREN;
    e_ren   = (m_kind == 1) ? (dREN & ~dWEN) : (m_kind == 2);
    e_wen   = (m_kind == 1) ? dWEN : 1'b0;
    e_addr  = (m_kind == 1) ? daddr : ((m_kind == 2) ? iaddr : 32'd0);
    e_store = (m_kind == 1) ? dstore : 32'd0;
    chk32({tag, ".ramREN"},   32'(ramREN),   32'(e_ren));
    chk32({tag, ".ramWEN"},   32'(ramWEN),   32'(e_wen));
    chk32({tag, ".ramaddr"},  ramaddr,       e_addr);
    chk32({tag, ".ramstore"}, ramstore,      e_store);
    chk32({tag, ".iwait"},    32'(iwait),    32'(m_parked | (iREN & ~i_done)));
    chk32({tag, ".dwait"},    32'(dwait),    32'(m_parked | ((dREN | dWEN) & ~d_done)));
    chk32({tag, ".iload"},    iload,         i_done ? ramload : 32'd0);
    chk32({tag, ".dload"},    dload,         (d_done && !m_wr) ? ramload : 32'd0);
    chk32({tag, ".err"},      32'(err),      32'(m_err));
    chk32({tag, ".halted"},   32'(halted),   32'(m_parked));
  endtask

  task automatic sample(input string tag);
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic adv();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    adv();
  endtask

  initial begin
    nRST = 0; halt = 0; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
    daddr = 0; dstore = 0; ramload = 0;
    model_reset();

    // Reset state, waits follow requests while in reset
    sample("rst");
    chk32("rst.halted", 32'(halted), 32'd0);
    chk32("rst.err", 32'(err), 32'd0);
    iREN = 1;
    #1;
    chk32("rst.iwait_follows", 32'(iwait), 32'd1);
    iREN = 0;
    adv();
    nRST = 1;
    step("idle");

    // Instruction read: RAM enabled cycles 1-2, completion in cycle 2
    iREN = 1; iaddr = 32'h0; ramload = 32'h1111_2222;
    adv();
    sample("t1.c1");
    chk32("t1.c1.ramREN", 32'(ramREN), 32'd1);
    chk32("t1.c1.iwait", 32'(iwait), 32'd1);
    adv();
    ramload = 32'h3C01_0001;
    sample("t1.c2");
    chk32("t1.c2.iwait", 32'(iwait), 32'd0);
    chk32("t1.c2.iload", iload, 32'h3C01_0001);
    adv();
    iREN = 0;
    sample("t1.c3");
    chk32("t1.c3.ramREN", 32'(ramREN), 32'd0);
    adv();
    step("t1.c4");

    // Data write
    dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    adv();
    sample("t2.c1");
    chk32("t2.c1.ramWEN", 32'(ramWEN), 32'd1);
    chk32("t2.c1.ramaddr", ramaddr, 32'h80);
    chk32("t2.c1.ramstore", ramstore, 32'hDEAD_BEEF);
    adv();
    sample("t2.c2");
    chk32("t2.c2.dwait", 32'(dwait), 32'd0);
    chk32("t2.c2.ramWEN", 32'(ramWEN), 32'd1);
    adv();
    dWEN = 0;
    sample("t2.c3");
    chk32("t2.c3.err", 32'(err), 32'd0);
    adv();
    step("t2.c4");

    // Simultaneous requests: data first, instruction after turnaround
    iREN = 1; iaddr = 32'h400; dREN = 1; daddr = 32'h1000; ramload = 32'hCAFE_0001;
    adv();
    sample("t3.c1");
    chk32("t3.c1.ramaddr", ramaddr, 32'h1000);
    adv();
    sample("t3.c2");
    chk32("t3.c2.dload", dload, 32'hCAFE_0001);
    adv();
    dREN = 0;
    step("t3.c3");
    sample("t3.c4");
    chk32("t3.c4.ramREN", 32'(ramREN), 32'd0);
    adv();
    sample("t3.c5");
    chk32("t3.c5.ramaddr", ramaddr, 32'h400);
    adv();
    sample("t3.c6");
    chk32("t3.c6.iwait", 32'(iwait), 32'd0);
    adv();
    iREN = 0;
    step("t3.c7");
    step("t3.c8");

    // dREN and dWEN together: treated as write, sticky error
    dREN = 1; dWEN = 1; daddr = 32'h44; dstore = 32'h1234_5678;
    adv();
    sample("t4.c1");
    chk32("t4.c1.ramWEN", 32'(ramWEN), 32'd1);
    chk32("t4.c1.ramREN", 32'(ramREN), 32'd0);
    adv();
    sample("t4.c2");
    chk32("t4.c2.err", 32'(err), 32'd1);
    adv();
    dREN = 0; dWEN = 0;
    for (int i = 0; i < 11; i++) step("t4.idle");
    chk32("t4.err_sticky", 32'(err), 32'd1);

    // Asynchronous reset in the first cycle of an access
    iREN = 1; iaddr = 32'h20;
    adv();
    #2;
    nRST = 0;
    #1;
    model_reset();
    chk32("t6.ramREN_drop", 32'(ramREN), 32'd0);
    chk32("t6.err_clear", 32'(err), 32'd0);
    sample("t6.inrst");
    adv();
    nRST = 1;
    step("t6.c0");
    step("t6.c1");
    sample("t6.c2");
    chk32("t6.c2.iwait", 32'(iwait), 32'd0);
    adv();
    iREN = 0;
    step("t6.c3");

    // Randomized requests against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) iREN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) dREN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) dWEN = ($urandom_range(0, 5) == 0);
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      step("rnd");
    end
    iREN = 0; dREN = 0; dWEN = 0;
    for (int i = 0; i < 4; i++) step("drain");

    // Halt during a data read: read finishes, then park
    dREN = 1; daddr = 32'h200; ramload = 32'h0BAD_F00D;
    adv();
    halt = 1;
    step("t5.c1");
    sample("t5.c2");
    chk32("t5.c2.dload", dload, 32'h0BAD_F00D);
    chk32("t5.c2.dwait", 32'(dwait), 32'd0);
    adv();
    dREN = 0;
    sample("t5.c3");
    chk32("t5.c3.halted", 32'(halted), 32'd0);
    adv();
    sample("t5.c4");
    chk32("t5.c4.halted", 32'(halted), 32'd1);
    adv();
    iREN = 1; iaddr = 32'h300;
    for (int i = 0; i < 4; i++) step("t5.park");
    chk32("t5.iwait", 32'(iwait), 32'd1);
    chk32("t5.ramREN", 32'(ramREN), 32'd0);

    // Reset releases the parked block
    nRST = 0; halt = 0; iREN = 0;
    #1;
    model_reset();
    adv();
    nRST = 1;
    step("post");
    chk32("post.halted", 32'(halted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
